// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with parametrised width/depth, occupancy count, programmable
// almost flags, sticky error flags and optional first-word-fall-through read port.
module sync_fifo_param #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter bit          FWFT     = 1'b0
) (
   input  logic                       clock,
   input  logic                       rst,
   input  logic                       wr,
   input  logic [WIDTH-1:0]           data_in,
   input  logic                       rd,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   localparam logic [CW-1:0] FullCount = CW'(DEPTH);
   localparam logic [CW-1:0] AfLevel   = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AeLevel   = CW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          overflow_q, overflow_d;
   logic          underflow_q, underflow_d;
   logic          rd_ok, wr_ok;

   // Flags decode only from the registered count: no rd/wr to flag paths.
   assign full         = (count_q == FullCount);
   assign empty        = (count_q == '0);
   assign almost_full  = (count_q >= AfLevel);
   assign almost_empty = (count_q <= AeLevel);
   assign count        = count_q;
   assign overflow     = overflow_q;
   assign underflow    = underflow_q;

   // A write into a full FIFO is accepted only when a read frees a slot the same edge.
   assign rd_ok = rd & ~empty;
   assign wr_ok = wr & (~full | rd_ok);

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q | (wr & ~wr_ok);
      underflow_d = underflow_q | (rd & empty);
      if (wr_ok) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (wr_ok && !rd_ok) begin
         count_d = count_q + CW'(1);
      end else if (rd_ok && !wr_ok) begin
         count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   // Storage carries no reset; stale entries are unreachable once pointers clear.
   always_ff @(posedge clock) begin
      if (!rst && wr_ok) begin
         mem[wr_ptr_q] <= data_in;
      end
   end

   if (FWFT) begin : g_fwft
      always_comb begin
         data_out = '0;
         if (!empty) begin
            data_out = mem[rd_ptr_q];
         end
      end
   end else begin : g_registered
      logic [WIDTH-1:0] data_out_q;

      always_ff @(posedge clock) begin
         if (rst) begin
            data_out_q <= '0;
         end else if (rd_ok) begin
            data_out_q <= mem[rd_ptr_q];
         end
      end

      assign data_out = data_out_q;
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: registered and FWFT instances share stimulus and are
// compared against a queue-based reference model, a hand-derived table and corner sequences.
module tb_sync_fifo_param;

   localparam int W = 8;
   localparam int D = 16;

   logic         clock = 1'b0;
   logic         rst   = 1'b1;
   logic         wr    = 1'b0;
   logic         rd    = 1'b0;
   logic [W-1:0] data_in = '0;

   logic [W-1:0] dout0, dout1;
   logic         full0, empty0, af0, ae0, ovf0, unf0;
   logic         full1, empty1, af1, ae1, ovf1, unf1;
   logic [4:0]   cnt0, cnt1;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model state
   logic [W-1:0] q[$];
   logic [W-1:0] m_dout0;
   bit           m_ovf, m_unf;

   always #5 clock = ~clock;

   sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1'b0)) u_reg (
      .clock(clock), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
      .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
      .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(unf0)
   );

   sync_fifo_param #(.WIDTH(W), .DEPTH(D), .FWFT(1'b1)) u_fwft (
      .clock(clock), .rst(rst), .wr(wr), .data_in(data_in), .rd(rd),
      .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
      .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(unf1)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at time %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model();
      int n;
      n = q.size();
      chk("count", 32'(cnt0), n);
      chk("count_fwft", 32'(cnt1), n);
      chk("full", 32'(full0), 32'(n == D));
      chk("empty", 32'(empty0), 32'(n == 0));
      chk("almost_full", 32'(af0), 32'(n >= D - 2));
      chk("almost_empty", 32'(ae0), 32'(n <= 2));
      chk("overflow", 32'(ovf0), 32'(m_ovf));
      chk("underflow", 32'(unf0), 32'(m_unf));
      chk("flags_fwft", {full1, empty1, af1, ae1, ovf1, unf1},
          {(n == D), (n == 0), (n >= D - 2), (n <= 2), m_ovf, m_unf});
      chk("data_out", 32'(dout0), 32'(m_dout0));
      chk("data_out_fwft", 32'(dout1), (n != 0) ? 32'(q[0]) : 32'd0);
   endtask

   // One clock: drive inputs, advance the model on pre-edge state, then compare.
   task automatic cycle(input bit w, input logic [W-1:0] d, input bit r, input bit rs);
      bit rd_ok, wr_ok;
      wr = w; data_in = d; rd = r; rst = rs;
      if (rs) begin
         q.delete();
         m_dout0 = '0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         rd_ok = r && (q.size() != 0);
         wr_ok = w && ((q.size() < D) || rd_ok);
         if (r && q.size() == 0) m_unf = 1'b1;
         if (w && !wr_ok) m_ovf = 1'b1;
         if (rd_ok) m_dout0 = q.pop_front();
         if (wr_ok) q.push_back(d);
      end
      @(posedge clock);
      #1;
      check_model();
   endtask

   typedef struct {
      bit           w;
      logic [W-1:0] d;
      bit           r;
      bit           rs;
      int           exp_cnt;
      logic [W-1:0] exp_dout0;
      logic [W-1:0] exp_dout1;
      bit           exp_unf;
   } vec_t;

   vec_t vecs[10];

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 8'h00, 1'b0};
      vecs[1] = '{1'b1, 8'h3C, 1'b0, 1'b0, 1, 8'h00, 8'h3C, 1'b0};
      vecs[2] = '{1'b1, 8'h11, 1'b0, 1'b0, 2, 8'h00, 8'h3C, 1'b0};
      vecs[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 8'h3C, 8'h11, 1'b0};
      vecs[4] = '{1'b1, 8'h22, 1'b1, 1'b0, 1, 8'h11, 8'h22, 1'b0};
      vecs[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h22, 8'h00, 1'b0};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h22, 8'h00, 1'b1};
      vecs[7] = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 8'h22, 8'h55, 1'b1};
      vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 8'h55, 8'h00, 1'b1};
      vecs[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 8'h00, 8'h00, 1'b0};

      m_dout0 = '0;
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);

      foreach (vecs[i]) begin
         cycle(vecs[i].w, vecs[i].d, vecs[i].r, vecs[i].rs);
         chk($sformatf("vec%0d_count", i), 32'(cnt0), vecs[i].exp_cnt);
         chk($sformatf("vec%0d_dout", i), 32'(dout0), 32'(vecs[i].exp_dout0));
         chk($sformatf("vec%0d_dout_fwft", i), 32'(dout1), 32'(vecs[i].exp_dout1));
         chk($sformatf("vec%0d_underflow", i), 32'(unf0), 32'(vecs[i].exp_unf));
      end

      // Fill to full, almost_full from 14, then a dropped 17th write.
      for (int i = 1; i <= D; i++) begin
         cycle(1'b1, 8'(i), 1'b0, 1'b0);
         chk("fill_af", 32'(af0), 32'(i >= 14));
      end
      chk("fill_full", 32'(full0), 1);
      chk("fill_count", 32'(cnt0), 16);
      cycle(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("ovf_set", 32'(ovf0), 1);
      chk("ovf_count", 32'(cnt0), 16);

      // Drain in order, then an extra read underflows and holds the last word.
      for (int i = 1; i <= D; i++) begin
         cycle(1'b0, 8'h00, 1'b1, 1'b0);
         chk("drain_data", 32'(dout0), i);
      end
      chk("drain_empty", 32'(empty0), 1);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("unf_set", 32'(unf0), 1);
      chk("unf_hold", 32'(dout0), 32'h10);

      // Simultaneous read/write while full.
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 1; i <= D; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 8'hAA, 1'b1, 1'b0);
      chk("full_rw_count", 32'(cnt0), 16);
      chk("full_rw_ovf", 32'(ovf0), 0);
      chk("full_rw_data", 32'(dout0), 1);
      for (int i = 0; i < D; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("full_rw_aa", 32'(dout0), 32'hAA);

      // Wrap: steady wr+rd at occupancy 3.
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 3; i < 43; i++) begin
         cycle(1'b1, 8'(i), 1'b1, 1'b0);
         chk("wrap_data", 32'(dout0), i - 3);
         chk("wrap_count", 32'(cnt0), 3);
      end

      // Reset at count 9 discards contents.
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      for (int i = 0; i < 9; i++) cycle(1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
      cycle(1'b1, 8'h00, 1'b1, 1'b0);
      cycle(1'b0, 8'h00, 1'b0, 1'b1);
      chk("rst9_state", {27'd0, cnt0}, 0);
      chk("rst9_flags", {empty0, ae0, full0, af0, ovf0, unf0}, 6'b110000);
      chk("rst9_dout", {dout1, dout0}, 0);
      cycle(1'b1, 8'h77, 1'b0, 1'b0);
      chk("rst9_fwft_new", 32'(dout1), 32'h77);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
      chk("rst9_new", 32'(dout0), 32'h77);

      // Randomised traffic with shifting bias so both full and empty are visited.
      for (int i = 0; i < 4000; i++) begin
         int wp, rp;
         wp = ((i / 250) % 2 == 0) ? 70 : 30;
         rp = 100 - wp;
         cycle($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < rp,
               $urandom_range(0, 599) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
